// File: rtl/err_stat_monitor.sv
// Error statistics over a window of approximate-multiplier samples.
// Ports: start/in_valid/in_ready/x/y/z_approx in; out_valid/out_ready/sum/max/count/bias out.
module err_stat_monitor #(
  parameter int WIN_LOG2 = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              x,
  input  logic [7:0]              y,
  input  logic [15:0]             z_approx,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [16+WIN_LOG2-1:0]  sum_abs_err,
  output logic [15:0]             max_abs_err,
  output logic [WIN_LOG2:0]       err_count,
  output logic [17+WIN_LOG2-1:0]  bias_sum
);

  localparam int WIN = 1 << WIN_LOG2;
  localparam int CW  = WIN_LOG2 + 1;
  localparam int SW  = 16 + WIN_LOG2;
  localparam int BW  = 17 + WIN_LOG2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            stg_vld_q, stg_vld_d;
  logic [7:0]      stg_x_q, stg_x_d;
  logic [7:0]      stg_y_q, stg_y_d;
  logic [15:0]     stg_z_q, stg_z_d;
  logic [SW-1:0]   sum_q, sum_d;
  logic [15:0]     max_q, max_d;
  logic [CW-1:0]   ecnt_q, ecnt_d;
  logic [BW-1:0]   bias_q, bias_d;

  logic            clr;
  logic            accept;
  logic            last;
  logic [15:0]     exact;
  logic [16:0]     err;
  logic [15:0]     abs_err;

  assign last    = (cnt_q == CW'(WIN - 1));
  assign exact   = 16'(stg_x_q) * 16'(stg_y_q);
  // 17-bit difference keeps the sign of an under-estimate.
  assign err     = {1'b0, stg_z_q} - {1'b0, exact};
  assign abs_err = err[16] ? 16'(-err) : err[15:0];

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          clr     = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (in_valid) begin
          accept = 1'b1;
          if (last) state_d = DRAIN;
        end
      end
      DRAIN:  state_d = REPORT;
      REPORT: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    stg_vld_d = accept;
    stg_x_d   = stg_x_q;
    stg_y_d   = stg_y_q;
    stg_z_d   = stg_z_q;
    sum_d     = sum_q;
    max_d     = max_q;
    ecnt_d    = ecnt_q;
    bias_d    = bias_q;
    if (accept) begin
      cnt_d   = cnt_q + CW'(1);
      stg_x_d = x;
      stg_y_d = y;
      stg_z_d = z_approx;
    end
    if (clr) begin
      cnt_d  = '0;
      sum_d  = '0;
      max_d  = '0;
      ecnt_d = '0;
      bias_d = '0;
    end else if (stg_vld_q) begin
      sum_d  = sum_q + SW'(abs_err);
      bias_d = bias_q + {{WIN_LOG2{err[16]}}, err};
      if (abs_err > max_q) max_d = abs_err;
      if (err != '0) ecnt_d = ecnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      stg_vld_q <= 1'b0;
      stg_x_q   <= '0;
      stg_y_q   <= '0;
      stg_z_q   <= '0;
      sum_q     <= '0;
      max_q     <= '0;
      ecnt_q    <= '0;
      bias_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stg_vld_q <= stg_vld_d;
      stg_x_q   <= stg_x_d;
      stg_y_q   <= stg_y_d;
      stg_z_q   <= stg_z_d;
      sum_q     <= sum_d;
      max_q     <= max_d;
      ecnt_q    <= ecnt_d;
      bias_q    <= bias_d;
    end
  end

  assign in_ready    = (state_q == RUN);
  assign out_valid   = (state_q == REPORT);
  assign sum_abs_err = sum_q;
  assign max_abs_err = max_q;
  assign err_count   = ecnt_q;
  assign bias_sum    = bias_q;

endmodule

// File: tb/tb_err_stat_monitor.sv
// Bench for err_stat_monitor: window sizes 4 and 256.
// Expected window statistics are queued as stimulus is built.
module tb_err_stat_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        s2, iv2, ir2, ov2, or2;
  logic [7:0]  x2, y2;
  logic [15:0] z2;
  logic [17:0] sum2;
  logic [15:0] max2;
  logic [2:0]  cnt2;
  logic [18:0] bias2;

  logic        s8, iv8, ir8, ov8, or8;
  logic [7:0]  x8, y8;
  logic [15:0] z8;
  logic [23:0] sum8;
  logic [15:0] max8;
  logic [8:0]  cnt8;
  logic [24:0] bias8;

  typedef struct {
    int sum;
    int mx;
    int cnt;
    int bias;
  } exp_t;

  exp_t sb2[$];
  exp_t sb8[$];

  int checks   = 0;
  int failures = 0;

  err_stat_monitor #(.WIN_LOG2(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(s2),
    .in_valid(iv2), .in_ready(ir2),
    .x(x2), .y(y2), .z_approx(z2),
    .out_valid(ov2), .out_ready(or2),
    .sum_abs_err(sum2), .max_abs_err(max2),
    .err_count(cnt2), .bias_sum(bias2)
  );

  err_stat_monitor #(.WIN_LOG2(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8),
    .in_valid(iv8), .in_ready(ir8),
    .x(x8), .y(y8), .z_approx(z8),
    .out_valid(ov8), .out_ready(or8),
    .sum_abs_err(sum8), .max_abs_err(max8),
    .err_count(cnt8), .bias_sum(bias8)
  );

  initial begin
    #500000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1);
  end

  task automatic start2();
    @(negedge clk);
    s2 = 1'b1;
    @(negedge clk);
    s2 = 1'b0;
  endtask

  task automatic send2(input logic [7:0] xa,
                       input logic [7:0] ya,
                       input logic [15:0] za);
    int w;
    w = 0;
    @(negedge clk);
    x2 = xa; y2 = ya; z2 = za; iv2 = 1'b1;
    while (ir2 !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (ir2 !== 1'b1) begin
      failures++;
      $display("FAIL send2_accept got in_ready=%b want 1", ir2);
    end
    @(posedge clk);
    #1;
    iv2 = 1'b0;
    x2 = 8'($urandom); y2 = 8'($urandom); z2 = 16'($urandom);
  endtask

  task automatic wait_ov2();
    int w;
    w = 0;
    @(negedge clk);
    while (ov2 !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (ov2 !== 1'b1) begin
      failures++;
      $display("FAIL wait_ov2 got out_valid=%b want 1", ov2);
    end
  endtask

  task automatic release2();
    @(negedge clk);
    or2 = 1'b1;
    @(negedge clk);
    or2 = 1'b0;
  endtask

  function automatic logic [15:0] mk_z(input logic [7:0] a,
                                       input logic [7:0] b,
                                       input int e);
    return 16'(int'(a) * int'(b) + e);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    s2 = 0; iv2 = 0; or2 = 0; x2 = 0; y2 = 0; z2 = 0;
    s8 = 0; iv8 = 0; or8 = 0; x8 = 0; y8 = 0; z8 = 0;
    #3;
    checks++;
    if ({ir2, ov2, ir8, ov8} !== 4'b0) begin
      failures++;
      $display("FAIL reset_hs got %b want 0000", {ir2, ov2, ir8, ov8});
    end
    checks++;
    if ({sum2, max2, cnt2, bias2} !== '0) begin
      failures++;
      $display("FAIL reset_stats2 got %0d/%0d/%0d/%0d want 0",
               sum2, max2, cnt2, bias2);
    end
    checks++;
    if ({sum8, max8, cnt8, bias8} !== '0) begin
      failures++;
      $display("FAIL reset_stats8 got %0d/%0d/%0d/%0d want 0",
               sum8, max8, cnt8, bias8);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_w8_exact();
    exp_t e;
    int n;
    int w;
    logic [7:0] xa, ya;
    sb8.push_back('{0, 0, 0, 0});
    @(negedge clk);
    s8 = 1'b1;
    @(negedge clk);
    s8 = 1'b0;
    n = 0;
    w = 0;
    while (n < 256 && w < 1000) begin
      xa = 8'($urandom); ya = 8'($urandom);
      x8 = xa; y8 = ya;
      z8 = 16'(xa) * 16'(ya);
      iv8 = ($urandom_range(0, 3) != 0);
      if (iv8 && ir8 === 1'b1) n++;
      w++;
      @(negedge clk);
    end
    iv8 = 1'b0;
    checks++;
    if (n != 256) begin
      failures++;
      $display("FAIL w8_accepts got %0d want 256", n);
    end
    w = 0;
    @(negedge clk);
    while (ov8 !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (ov8 !== 1'b1) begin
      failures++;
      $display("FAIL w8_ov got %b want 1", ov8);
    end
    e = sb8.pop_front();
    checks++;
    if (32'(sum8) !== e.sum) begin
      failures++;
      $display("FAIL w8_sum got %0d want %0d", sum8, e.sum);
    end
    checks++;
    if (32'(max8) !== e.mx) begin
      failures++;
      $display("FAIL w8_max got %0d want %0d", max8, e.mx);
    end
    checks++;
    if (32'(cnt8) !== e.cnt) begin
      failures++;
      $display("FAIL w8_cnt got %0d want %0d", cnt8, e.cnt);
    end
    checks++;
    if (32'($signed(bias8)) !== e.bias) begin
      failures++;
      $display("FAIL w8_bias got %0d want %0d", $signed(bias8), e.bias);
    end
    @(negedge clk);
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    checks++;
    if (ov8 !== 1'b0) begin
      failures++;
      $display("FAIL w8_release got %b want 0", ov8);
    end
  endtask

  task automatic test_plus3();
    exp_t e;
    logic [7:0] xa, ya;
    @(negedge clk);
    iv2 = 1'b1; x2 = 8'hff; y2 = 8'h01; z2 = 16'h1234;
    repeat (3) @(negedge clk);
    checks++;
    if (ir2 !== 1'b0 || ov2 !== 1'b0) begin
      failures++;
      $display("FAIL idle_hs got %b%b want 00", ir2, ov2);
    end
    iv2 = 1'b0;
    start2();
    checks++;
    if (ir2 !== 1'b1) begin
      failures++;
      $display("FAIL plus3_run got in_ready=%b want 1", ir2);
    end
    sb2.push_back('{12, 3, 4, 12});
    for (int i = 0; i < 4; i++) begin
      xa = 8'($urandom); ya = 8'($urandom);
      send2(xa, ya, mk_z(xa, ya, 3));
    end
    iv2 = 1'b1;
    @(negedge clk);
    checks++;
    if (ov2 !== 1'b0 || ir2 !== 1'b0) begin
      failures++;
      $display("FAIL plus3_drain got ov=%b ir=%b want 0 0", ov2, ir2);
    end
    @(negedge clk);
    iv2 = 1'b0;
    checks++;
    if (ov2 !== 1'b1) begin
      failures++;
      $display("FAIL plus3_latency got ov=%b want 1", ov2);
    end
    e = sb2.pop_front();
    checks++;
    if (32'(sum2) !== e.sum) begin
      failures++;
      $display("FAIL plus3_sum got %0d want %0d", sum2, e.sum);
    end
    checks++;
    if (32'(max2) !== e.mx) begin
      failures++;
      $display("FAIL plus3_max got %0d want %0d", max2, e.mx);
    end
    checks++;
    if (32'(cnt2) !== e.cnt) begin
      failures++;
      $display("FAIL plus3_cnt got %0d want %0d", cnt2, e.cnt);
    end
    checks++;
    if (32'($signed(bias2)) !== e.bias) begin
      failures++;
      $display("FAIL plus3_bias got %0d want %0d", $signed(bias2), e.bias);
    end
    release2();
    checks++;
    if (ov2 !== 1'b0) begin
      failures++;
      $display("FAIL plus3_release got %b want 0", ov2);
    end
  endtask

  task automatic test_gaps();
    exp_t e;
    sb2.push_back('{12, 5, 3, -2});
    start2();
    send2(8'd10, 8'd20, 16'd205);
    repeat (2) @(negedge clk);
    send2(8'd3, 8'd7, 16'd16);
    repeat (3) @(negedge clk);
    send2(8'd9, 8'd9, 16'd81);
    @(negedge clk);
    send2(8'd50, 8'd4, 16'd198);
    wait_ov2();
    e = sb2.pop_front();
    checks++;
    if (32'(sum2) !== e.sum) begin
      failures++;
      $display("FAIL gaps_sum got %0d want %0d", sum2, e.sum);
    end
    checks++;
    if (32'(max2) !== e.mx) begin
      failures++;
      $display("FAIL gaps_max got %0d want %0d", max2, e.mx);
    end
    checks++;
    if (32'(cnt2) !== e.cnt) begin
      failures++;
      $display("FAIL gaps_cnt got %0d want %0d", cnt2, e.cnt);
    end
    checks++;
    if (32'($signed(bias2)) !== e.bias) begin
      failures++;
      $display("FAIL gaps_bias got %0d want %0d", $signed(bias2), e.bias);
    end
    release2();
  endtask

  task automatic test_max_err();
    exp_t e;
    sb2.push_back('{260100, 65025, 4, -260100});
    start2();
    for (int i = 0; i < 4; i++) send2(8'd255, 8'd255, 16'd0);
    wait_ov2();
    e = sb2.pop_front();
    checks++;
    if (32'(sum2) !== e.sum) begin
      failures++;
      $display("FAIL max_sum got %0d want %0d", sum2, e.sum);
    end
    checks++;
    if (32'(max2) !== e.mx) begin
      failures++;
      $display("FAIL max_max got %0d want %0d", max2, e.mx);
    end
    checks++;
    if (32'(cnt2) !== e.cnt) begin
      failures++;
      $display("FAIL max_cnt got %0d want %0d", cnt2, e.cnt);
    end
    checks++;
    if (32'($signed(bias2)) !== e.bias) begin
      failures++;
      $display("FAIL max_bias got %0d want %0d", $signed(bias2), e.bias);
    end
    release2();
  endtask

  task automatic test_report_hold();
    exp_t e;
    logic [7:0] xa, ya;
    sb2.push_back('{10, 4, 4, 10});
    start2();
    for (int i = 1; i <= 4; i++) begin
      xa = 8'($urandom); ya = 8'($urandom);
      send2(xa, ya, mk_z(xa, ya, i));
    end
    wait_ov2();
    e = sb2.pop_front();
    for (int i = 0; i < 10; i++) begin
      s2 = (i == 3);
      checks++;
      if (ov2 !== 1'b1 || 32'(sum2) !== e.sum || 32'(max2) !== e.mx
          || 32'(cnt2) !== e.cnt
          || 32'($signed(bias2)) !== e.bias) begin
        failures++;
        $display("FAIL hold_%0d got ov=%b %0d/%0d/%0d/%0d want 1 %0d/%0d/%0d/%0d",
                 i, ov2, sum2, max2, cnt2, $signed(bias2),
                 e.sum, e.mx, e.cnt, e.bias);
      end
      @(negedge clk);
    end
    s2 = 1'b0;
    or2 = 1'b1;
    @(negedge clk);
    or2 = 1'b0;
    checks++;
    if (ov2 !== 1'b0 || ir2 !== 1'b0) begin
      failures++;
      $display("FAIL hold_release got ov=%b ir=%b want 0 0", ov2, ir2);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (32'(sum2) !== e.sum || 32'(max2) !== e.mx || ir2 !== 1'b0) begin
      failures++;
      $display("FAIL idle_keep got %0d/%0d ir=%b want %0d/%0d 0",
               sum2, max2, ir2, e.sum, e.mx);
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    logic [7:0] xa, ya;
    start2();
    send2(8'd12, 8'd11, mk_z(8'd12, 8'd11, 7));
    send2(8'd40, 8'd2, mk_z(8'd40, 8'd2, 7));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ir2, ov2, sum2, max2, cnt2, bias2} !== '0) begin
      failures++;
      $display("FAIL midrst_zero got ir=%b ov=%b %0d/%0d/%0d/%0d want 0",
               ir2, ov2, sum2, max2, cnt2, bias2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (ov2 !== 1'b0 || ir2 !== 1'b0) begin
        failures++;
        $display("FAIL midrst_idle got ov=%b ir=%b want 0 0", ov2, ir2);
      end
    end
    sb2.push_back('{4, 1, 4, 4});
    start2();
    for (int i = 0; i < 4; i++) begin
      xa = 8'($urandom); ya = 8'($urandom);
      send2(xa, ya, mk_z(xa, ya, 1));
    end
    wait_ov2();
    e = sb2.pop_front();
    checks++;
    if (32'(sum2) !== e.sum || 32'(max2) !== e.mx
        || 32'(cnt2) !== e.cnt || 32'($signed(bias2)) !== e.bias) begin
      failures++;
      $display("FAIL midrst_clean got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
               sum2, max2, cnt2, $signed(bias2),
               e.sum, e.mx, e.cnt, e.bias);
    end
    release2();
  endtask

  task automatic test_random();
    exp_t e;
    logic [7:0]  xs[4];
    logic [7:0]  ys[4];
    logic [15:0] zs[4];
    int d;
    int a;
    for (int w = 0; w < 4; w++) begin
      e = '{0, 0, 0, 0};
      for (int i = 0; i < 4; i++) begin
        xs[i] = 8'($urandom);
        ys[i] = 8'($urandom);
        zs[i] = ($urandom_range(0, 2) == 0) ?
                16'(int'(xs[i]) * int'(ys[i])) : 16'($urandom);
        d = int'(zs[i]) - int'(xs[i]) * int'(ys[i]);
        a = (d < 0) ? -d : d;
        e.sum += a;
        e.bias += d;
        if (a > e.mx) e.mx = a;
        if (d != 0) e.cnt++;
      end
      sb2.push_back(e);
      start2();
      for (int i = 0; i < 4; i++) send2(xs[i], ys[i], zs[i]);
      wait_ov2();
      e = sb2.pop_front();
      checks++;
      if (32'(sum2) !== e.sum || 32'(max2) !== e.mx
          || 32'(cnt2) !== e.cnt || 32'($signed(bias2)) !== e.bias) begin
        failures++;
        $display("FAIL rand_%0d got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                 w, sum2, max2, cnt2, $signed(bias2),
                 e.sum, e.mx, e.cnt, e.bias);
      end
      release2();
    end
  endtask

  initial begin
    test_reset();
    test_w8_exact();
    test_plus3();
    test_gaps();
    test_max_err();
    test_report_hold();
    test_mid_reset();
    test_random();
    checks++;
    if (sb2.size() != 0 || sb8.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got %0d/%0d want 0/0",
               sb2.size(), sb8.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
